mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the core's instruction-fetch requester and its load/store data requester.
- Sequences each access with a small FSM and a latency counter, and returns read data to the winning requester with a one-cycle ack pulse.
- Drives a stall output so the core's program counter and register-file write can be held while an access is outstanding.
- Sits between the core's fetch/data interfaces and the memory macro.

---
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Core-side fetch/data handshakes and memory-macro bus shared by mem_port_arbiter.
// Signal directions are named from the arbiter's point of view.
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH_P      = 32,
    parameter int DATA_ADDR_WIDTH_P = 32
);
    logic                         i_if_req;
    logic [DATA_ADDR_WIDTH_P-1:0] i_if_addr;
    logic                         o_if_ack;
    logic [DATA_WIDTH_P-1:0]      o_if_rd_data;

    logic                         i_d_req;
    logic                         i_d_wr_en;
    logic [DATA_ADDR_WIDTH_P-1:0] i_d_addr;
    logic [DATA_WIDTH_P-1:0]      i_d_wr_data;
    logic                         o_d_ack;
    logic [DATA_WIDTH_P-1:0]      o_d_rd_data;

    logic                         o_mem_en;
    logic                         o_mem_wr_en;
    logic [DATA_ADDR_WIDTH_P-1:0] o_mem_addr;
    logic [DATA_WIDTH_P-1:0]      o_mem_wr_data;
    logic [DATA_WIDTH_P-1:0]      i_mem_rd_data;

    logic                         o_stall;

    modport slave (
        input  i_if_req, i_if_addr, i_d_req, i_d_wr_en, i_d_addr, i_d_wr_data, i_mem_rd_data,
        output o_if_ack, o_if_rd_data, o_d_ack, o_d_rd_data,
        output o_mem_en, o_mem_wr_en, o_mem_addr, o_mem_wr_data, o_stall
    );

    modport master (
        output i_if_req, i_if_addr, i_d_req, i_d_wr_en, i_d_addr, i_d_wr_data, i_mem_rd_data,
        input  o_if_ack, o_if_rd_data, o_d_ack, o_d_rd_data,
        input  o_mem_en, o_mem_wr_en, o_mem_addr, o_mem_wr_data, o_stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store data.
// Define MEM_PORT_ARBITER_RR_EN for round-robin arbitration (default: data over fetch).
module mem_port_arbiter #(
    parameter int DATA_WIDTH_P      = 32,
    parameter int DATA_ADDR_WIDTH_P = 32,
    parameter int MEM_LAT_P         = 1
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic                         r_gnt_d;
    logic                         r_wr;
    logic [DATA_ADDR_WIDTH_P-1:0] r_addr;
    logic [DATA_WIDTH_P-1:0]      r_wdata;
    logic [CNT_W-1:0]             r_cnt;
    logic [DATA_WIDTH_P-1:0]      r_if_rd;
    logic [DATA_WIDTH_P-1:0]      r_d_rd;

    logic w_if_ack;
    logic w_d_ack;
    logic w_if_elig;
    logic w_d_elig;
    logic w_pick_d;
    logic w_grant;
    logic w_load_cnt;
    logic w_capture;

    assign w_if_ack  = (r_state == S_RESP) & ~r_gnt_d;
    assign w_d_ack   = (r_state == S_RESP) &  r_gnt_d;
    // A requester being acked this cycle is not asking for a new access yet.
    assign w_if_elig = bus.i_if_req & ~w_if_ack;
    assign w_d_elig  = bus.i_d_req  & ~w_d_ack;

`ifdef MEM_PORT_ARBITER_RR_EN
    logic r_last_d;

    assign w_pick_d = w_d_elig & (~w_if_elig | ~r_last_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_d <= 1'b0;
        end else if (w_grant) begin
            r_last_d <= w_pick_d;
        end
    end
`else
    // Data first, so the instruction already in flight finishes its memory op.
    assign w_pick_d = w_d_elig;
`endif

    always_comb begin
        w_next     = r_state;
        w_grant    = 1'b0;
        w_load_cnt = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_if_elig | w_d_elig) begin
                    w_grant = 1'b1;
                    w_next  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_wr) begin
                    w_next = S_RESP;
                end else begin
                    w_load_cnt = 1'b1;
                    w_next     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_capture = 1'b1;
                    w_next    = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_gnt_d <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_if_rd <= '0;
            r_d_rd  <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_gnt_d <= w_pick_d;
                r_wr    <= w_pick_d & bus.i_d_wr_en;
                r_addr  <= w_pick_d ? bus.i_d_addr : bus.i_if_addr;
                if (w_pick_d) begin
                    r_wdata <= bus.i_d_wr_data;
                end
            end
            if (w_load_cnt) begin
                r_cnt <= CNT_W'(MEM_LAT_P - 1);
            end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_capture) begin
                if (r_gnt_d) begin
                    r_d_rd <= bus.i_mem_rd_data;
                end else begin
                    r_if_rd <= bus.i_mem_rd_data;
                end
            end
        end
    end

    assign bus.o_mem_en      = (r_state == S_ISSUE);
    assign bus.o_mem_wr_en   = (r_state == S_ISSUE) & r_wr;
    assign bus.o_mem_addr    = r_addr;
    assign bus.o_mem_wr_data = r_wdata;
    assign bus.o_if_ack      = w_if_ack;
    assign bus.o_d_ack       = w_d_ack;
    assign bus.o_if_rd_data  = r_if_rd;
    assign bus.o_d_rd_data   = r_d_rd;
    assign bus.o_stall       = (bus.i_if_req & ~w_if_ack) | (bus.i_d_req & ~w_d_ack);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-schedule model plus pinned literals.
module tb_mem_port_arbiter;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int LAT = 3;

    localparam int S_EN = 0, S_WR = 1, S_ADDR = 2, S_WDATA = 3, S_IFACK = 4, S_IFRD = 5;
    localparam int S_DACK = 6, S_DRD = 7, S_STALL = 8, S_NEN = 9, S_NIFACK = 10;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } dreq_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    typedef struct {
        int          c;
        int          sel;
        logic [31:0] exp;
        string       nm;
    } lit_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.DATA_WIDTH_P(DW), .DATA_ADDR_WIDTH_P(AW)) bus ();

    mem_port_arbiter #(
        .DATA_WIDTH_P(DW), .DATA_ADDR_WIDTH_P(AW), .MEM_LAT_P(LAT)
    ) dut (
        .clk(clk), .reset(rst), .bus(bus)
    );

    logic [31:0] fq[$];
    dreq_t       dq[$];
    rd_t         pq[$];
    lit_t        lits[$];
    logic [31:0] mem [logic [31:0]];

    int nvec = 0;
    int nerr = 0;
    int n_en = 0;
    int n_ifack = 0;

    // transaction model: one access at a time, scheduled from its grant cycle
    bit          m_busy = 0;
    bit          m_win_d = 0;
    bit          m_wr = 0;
    bit          m_last_d = 0;
    int          m_n = 0;
    int          m_ack = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdexp = '0;
    logic [31:0] e_maddr = '0, e_mwdata = '0, e_if_rd = '0, e_d_rd = '0;
    bit          e_en, e_wr, e_ia, e_da, e_st;
    bit          prev_if_ack = 0, prev_d_ack = 0;

    function automatic logic [31:0] rdval(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            S_EN:     return 32'(bus.o_mem_en);
            S_WR:     return 32'(bus.o_mem_wr_en);
            S_ADDR:   return bus.o_mem_addr;
            S_WDATA:  return bus.o_mem_wr_data;
            S_IFACK:  return 32'(bus.o_if_ack);
            S_IFRD:   return bus.o_if_rd_data;
            S_DACK:   return 32'(bus.o_d_ack);
            S_DRD:    return bus.o_d_rd_data;
            S_STALL:  return 32'(bus.o_stall);
            S_NEN:    return 32'(n_en);
            S_NIFACK: return 32'(n_ifack);
            default:  return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (cyc == 1) begin
                mem[32'h40] = 32'h2008_0005;
                mem[32'h20] = 32'h1234_5678;
            end
            if (m_busy && cyc > m_ack) m_busy = 0;
            if (!m_busy && !rst && (bus.i_if_req || bus.i_d_req)) begin
`ifdef MEM_PORT_ARBITER_RR_EN
                m_win_d = bus.i_d_req && (!bus.i_if_req || !m_last_d);
`else
                m_win_d = bus.i_d_req;
`endif
                m_last_d = m_win_d;
                m_wr     = m_win_d && bus.i_d_wr_en;
                m_addr   = m_win_d ? bus.i_d_addr : bus.i_if_addr;
                if (m_win_d) m_wdata = bus.i_d_wr_data;
                m_rdexp  = rdval(m_addr);
                m_n      = cyc;
                m_ack    = cyc + 2 + (m_wr ? 0 : LAT);
                m_busy   = 1;
            end
            e_en = m_busy && (cyc == m_n + 1);
            e_wr = e_en && m_wr;
            if (e_en) begin
                e_maddr  = m_addr;
                e_mwdata = m_wdata;
            end
            e_ia = m_busy && (cyc == m_ack) && !m_win_d;
            e_da = m_busy && (cyc == m_ack) &&  m_win_d;
            if (m_busy && (cyc == m_ack) && !m_wr) begin
                if (m_win_d) e_d_rd = m_rdexp;
                else         e_if_rd = m_rdexp;
            end
            e_st = (bus.i_if_req && !e_ia) || (bus.i_d_req && !e_da);

            chk("mem_en",      32'(bus.o_mem_en),    32'(e_en));
            chk("mem_wr_en",   32'(bus.o_mem_wr_en), 32'(e_wr));
            chk("mem_addr",    bus.o_mem_addr,       e_maddr);
            chk("mem_wr_data", bus.o_mem_wr_data,    e_mwdata);
            chk("if_ack",      32'(bus.o_if_ack),    32'(e_ia));
            chk("if_rd_data",  bus.o_if_rd_data,     e_if_rd);
            chk("d_ack",       32'(bus.o_d_ack),     32'(e_da));
            chk("d_rd_data",   bus.o_d_rd_data,      e_d_rd);
            chk("stall",       32'(bus.o_stall),     32'(e_st));

            // memory macro behaviour, driven by what the DUT actually issues
            if (bus.o_mem_en === 1'b1) begin
                if (bus.o_mem_wr_en === 1'b1) mem[bus.o_mem_addr] = bus.o_mem_wr_data;
                else pq.push_back('{cyc + LAT, rdval(bus.o_mem_addr)});
            end
            n_en    += (bus.o_mem_en === 1'b1) ? 1 : 0;
            n_ifack += (bus.o_if_ack === 1'b1) ? 1 : 0;

            foreach (lits[i]) begin
                if (lits[i].c == cyc) chk(lits[i].nm, sample(lits[i].sel), lits[i].exp);
            end

            prev_if_ack = e_ia;
            prev_d_ack  = e_da;
            if (rst) begin
                m_busy = 0; m_last_d = 0; m_wdata = '0;
                e_maddr = '0; e_mwdata = '0; e_if_rd = '0; e_d_rd = '0;
            end
        end
    end

    task automatic lit(input int c, input int sel, input logic [31:0] exp, input string nm);
        lits.push_back('{c, sel, exp, nm});
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (prev_if_ack && fq.size() != 0) void'(fq.pop_front());
        if (prev_d_ack && dq.size() != 0) void'(dq.pop_front());
        bus.i_if_req = (fq.size() != 0);
        if (fq.size() != 0) bus.i_if_addr = fq[0];
        bus.i_d_req = (dq.size() != 0);
        if (dq.size() != 0) begin
            bus.i_d_wr_en   = dq[0].wr;
            bus.i_d_addr    = dq[0].addr;
            bus.i_d_wr_data = dq[0].data;
        end
        while (pq.size() != 0 && pq[0].due < cyc) void'(pq.pop_front());
        if (pq.size() != 0 && pq[0].due == cyc) bus.i_mem_rd_data = pq.pop_front().data;
        else bus.i_mem_rd_data = 32'h5A5A_0000 | 32'(cyc);
    endtask

    task automatic drain();
        int k = 0;
        while ((fq.size() != 0 || dq.size() != 0 || m_busy) && k < 300) begin
            cycle();
            k++;
        end
        if (k >= 300) begin
            $display("FAIL drain_timeout @cyc %0d: got pending work, want idle", cyc);
            $fatal(1, "drain timeout");
        end
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog @cyc %0d: got no finish, want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base_en, base_ia;
        bus.i_if_req = 0; bus.i_if_addr = '0;
        bus.i_d_req = 0; bus.i_d_wr_en = 0; bus.i_d_addr = '0; bus.i_d_wr_data = '0;
        bus.i_mem_rd_data = '0;

        // reset state
        lit(2, S_EN, 0, "rst_mem_en");
        lit(2, S_ADDR, 0, "rst_mem_addr");
        lit(2, S_IFACK, 0, "rst_if_ack");
        lit(2, S_DRD, 0, "rst_d_rd");
        lit(2, S_STALL, 0, "rst_stall");
        repeat (3) cycle();
        rst = 0;
        cycle();

        // single fetch
        fq.push_back(32'h40);
        cycle(); n = cyc;
        lit(n + 1, S_EN, 1, "f_mem_en");
        lit(n + 1, S_ADDR, 32'h40, "f_mem_addr");
        lit(n + 1 + LAT, S_IFACK, 0, "f_no_early_ack");
        lit(n + 2 + LAT, S_IFACK, 1, "f_if_ack");
        lit(n + 2 + LAT, S_IFRD, 32'h2008_0005, "f_if_rd");
        drain();

        // single store
        dq.push_back('{1'b1, 32'h10, 32'hDEAD_BEEF});
        cycle(); n = cyc;
        lit(n + 1, S_EN, 1, "st_mem_en");
        lit(n + 1, S_WR, 1, "st_mem_wr");
        lit(n + 1, S_ADDR, 32'h10, "st_mem_addr");
        lit(n + 1, S_WDATA, 32'hDEAD_BEEF, "st_mem_wdata");
        lit(n + 2, S_DACK, 1, "st_d_ack");
        lit(n + 2, S_DRD, 0, "st_d_rd_unchanged");
        drain();

        // load with a request address change after grant
        dq.push_back('{1'b0, 32'h20, 32'h0});
        cycle(); n = cyc;
        lit(n, S_STALL, 1, "ld_stall_n");
        lit(n + 1, S_ADDR, 32'h20, "ld_mem_addr");
        lit(n + 1 + LAT, S_STALL, 1, "ld_stall_last");
        lit(n + 1 + LAT, S_DRD, 0, "ld_d_rd_before");
        lit(n + 2 + LAT, S_DACK, 1, "ld_d_ack");
        lit(n + 2 + LAT, S_DRD, 32'h1234_5678, "ld_d_rd");
        lit(n + 2 + LAT, S_STALL, 0, "ld_stall_ack");
        cycle();
        dq[0].addr = 32'h24;
        drain();

        // read back the stored word
        dq.push_back('{1'b0, 32'h10, 32'h0});
        drain();
        lit(cyc + 1, S_DRD, 32'hDEAD_BEEF, "ldback_d_rd");
        cycle();

        // contention: load + store on data, fetch waiting
        dq.push_back('{1'b0, 32'h20, 32'h0});
        dq.push_back('{1'b1, 32'h30, 32'hA5A5_0030});
        fq.push_back(32'h44);
        cycle(); n = cyc;
        lit(n + 1, S_ADDR, 32'h20, "ct_first_addr");
        lit(n + 2 + LAT, S_DACK, 1, "ct_d_ack");
        lit(n + 2 + LAT, S_IFACK, 0, "ct_if_wait");
        lit(n + 4 + LAT, S_EN, 1, "ct_second_en");
`ifdef MEM_PORT_ARBITER_RR_EN
        lit(n + 4 + LAT, S_ADDR, 32'h44, "ct_second_addr");
`else
        lit(n + 4 + LAT, S_ADDR, 32'h30, "ct_second_addr");
`endif
        drain();

        // reset while a fetch is waiting on memory
        fq.push_back(32'h80);
        cycle(); n = cyc;
        lit(n + 4, S_EN, 0, "rw_mem_en");
        lit(n + 4, S_IFACK, 0, "rw_if_ack");
        lit(n + 4, S_ADDR, 0, "rw_mem_addr");
        lit(n + 4, S_WDATA, 0, "rw_mem_wdata");
        lit(n + 4, S_IFRD, 0, "rw_if_rd");
        lit(n + 5, S_EN, 1, "rw_restart_en");
        lit(n + 5, S_ADDR, 32'h80, "rw_restart_addr");
        while (cyc < n + 3) cycle();
        rst = 1;
        cycle();
        rst = 0;
        drain();

        // continuous fetches
        base_en = n_en;
        base_ia = n_ifack;
        for (int i = 0; i < 5; i++) fq.push_back(32'h100 + 32'(4 * i));
        drain();
        lit(cyc + 1, S_NEN, 32'(base_en + 5), "cf_mem_en_count");
        lit(cyc + 1, S_NIFACK, 32'(base_ia + 5), "cf_if_ack_count");
        repeat (3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
